// File: rtl/sram_pkg.sv
// Shared definitions for the 32-bit-to-16-bit SRAM responder: state encoding,
// half-word width and default base address.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int HALF_W            = 16;
  localparam int DEFAULT_ADDR_BASE = 1024;

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state counter for one half-word phase; flags the final cycle of the phase.
module sram_phase_counter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign last = (r_count == LAST_CNT);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage responder: serves one 32-bit request as two wait-stated 16-bit
// SRAM accesses (low half, then high half), stalling the pipeline via ready.
module sram_controller
  import sram_pkg::*;
#(
  parameter int ADDR_BASE     = DEFAULT_ADDR_BASE,
  parameter int SRAM_ADDR_W   = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [HALF_W-1:0]      sram_dq_out,
  input  logic [HALF_W-1:0]      sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_wr;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [HALF_W-1:0]      r_dq_out;
  logic                   r_dq_oe;
  logic                   r_we_n;

  logic                   w_req;
  logic                   w_ready;
  logic                   w_last;
  logic                   w_in_phase;
  logic                   w_from_idle;
  logic                   w_wr_sel;
  logic [31:0]            w_addr_sel;
  logic [31:0]            w_wdata_sel;
  logic [31:0]            w_off;
  logic                   w_unused;

  assign w_req       = rd_en | wr_en;
  assign w_in_phase  = (r_state == LOW) || (r_state == HIGH);
  assign w_from_idle = (r_state == IDLE);

  // The SRAM output registers load on the edge that enters a phase, so while
  // still in IDLE the request comes straight from the inputs, not the latch.
  assign w_wr_sel    = w_from_idle ? wr_en      : r_wr;
  assign w_addr_sel  = w_from_idle ? address    : r_addr;
  assign w_wdata_sel = w_from_idle ? write_data : r_wdata;
  assign w_off       = w_addr_sel - 32'(ADDR_BASE);
  assign w_unused    = ^{w_off[31:SRAM_ADDR_W+1], w_off[1:0]};

  sram_phase_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (~w_in_phase | w_last),
    .enable(w_in_phase),
    .last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = ~w_req;
        if (w_req) w_next = LOW;
      end
      LOW: begin
        if (w_last) w_next = HIGH;
      end
      HIGH: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_ready = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= 1'b0;
    end else if (w_from_idle && w_req) begin
      r_wr <= wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (w_from_idle && w_req) begin
      r_addr  <= address;
      r_wdata <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (w_next)
        LOW: begin
          r_sram_addr <= {w_off[SRAM_ADDR_W:2], 1'b0};
          r_dq_oe     <= w_wr_sel;
          r_we_n      <= ~w_wr_sel;
          if (w_wr_sel) r_dq_out <= w_wdata_sel[HALF_W-1:0];
        end
        HIGH: begin
          r_sram_addr <= {w_off[SRAM_ADDR_W:2], 1'b1};
          r_dq_oe     <= w_wr_sel;
          r_we_n      <= ~w_wr_sel;
          if (w_wr_sel) r_dq_out <= w_wdata_sel[2*HALF_W-1:HALF_W];
        end
        default: begin
          r_dq_oe <= 1'b0;
          r_we_n  <= 1'b1;
        end
      endcase
    end
  end

  // Each half is captured on the final wait-state cycle of its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= '0;
    end else if (!r_wr && w_last) begin
      if (r_state == LOW)  r_read_data[HALF_W-1:0]        <= sram_dq_in;
      if (r_state == HIGH) r_read_data[2*HALF_W-1:HALF_W] <= sram_dq_in;
    end
  end

  assign read_data   = r_read_data;
  assign ready       = w_ready;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;

endmodule
